dram_req_scheduler: RTL

Parametrised successor to the request queue between the trace parser and the DRAM command side. It buffers up to QUEUE_SIZE parser requests and tracks per-bank open rows. Requests are issued at a divided rate with open-row-hit priority and an age-based starvation override. Issue is blocked during periodic refresh, which closes all banks.

---
 rtl/dram_req_scheduler_pkg.sv | 37 +++
 rtl/dram_req_scheduler_refresh_timer.sv | 52 +++++
 rtl/dram_req_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_req_scheduler_pkg.sv
// Shared types and DRAM address-field layout for the request scheduler.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package dram_req_scheduler_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2
    } opcode_t;

    // Address layout, LSB first: 3-bit burst byte offset, column, bank,
    // bank group, row. Sized for the default 33-bit request address.
    localparam int COLUMN_OFFSET = 3;
    localparam int COL_W         = 10;
    localparam int BANK_OFFSET   = 13;
    localparam int BANK_W        = 2;
    localparam int BG_OFFSET     = 15;
    localparam int BG_W          = 2;
    localparam int ROW_OFFSET    = 17;
    localparam int ROW_W         = 16;

    localparam logic [COL_W-1:0]  COL_MASK  = '1;
    localparam logic [BANK_W-1:0] BANK_MASK = '1;
    localparam logic [BG_W-1:0]   BG_MASK   = '1;
    localparam logic [ROW_W-1:0]  ROW_MASK  = '1;

    // Banks are addressed as {bank group, bank}.
    localparam int BANK_ID_W = BG_W + BANK_W;
    localparam int NUM_BANKS = 1 << BANK_ID_W;

    typedef struct packed {
        logic             open;
        logic [ROW_W-1:0] row;
    } bank_status_t;

endpackage

// File: rtl/dram_req_scheduler_refresh_timer.sv
// Periodic refresh timer: refresh_start pulses in the last cycle of each
// T_REFI-cycle interval, then refresh_active is high for T_RFC cycles.
// Latency: refresh_active rises on the edge after refresh_start; no backpressure.
//
// Ports: clk, rst_n (async active-low), refresh_active (busy window),
//        refresh_start (one-cycle warning, combinational from the counter).
module dram_req_scheduler_refresh_timer #(
    parameter int T_REFI = 7800,
    parameter int T_RFC  = 350
) (
    input  logic clk,
    input  logic rst_n,
    output logic refresh_active,
    output logic refresh_start
);

    localparam int REFI_W = $clog2(T_REFI);
    localparam int RFC_W  = (T_RFC > 1) ? $clog2(T_RFC) : 1;

    logic [REFI_W-1:0] refi_cnt;
    logic [RFC_W-1:0]  rfc_cnt;

    // Interval counter keeps running through the busy window, so the
    // refresh period stays exactly T_REFI cycles.
    assign refresh_start = (refi_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refi_cnt       <= REFI_W'(T_REFI - 1);
            rfc_cnt        <= '0;
            refresh_active <= 1'b0;
        end else begin
            if (refresh_start) begin
                refi_cnt <= REFI_W'(T_REFI - 1);
            end else begin
                refi_cnt <= refi_cnt - REFI_W'(1);
            end

            if (refresh_start) begin
                refresh_active <= 1'b1;
                rfc_cnt        <= RFC_W'(T_RFC - 1);
            end else if (refresh_active) begin
                if (rfc_cnt == '0) begin
                    refresh_active <= 1'b0;
                end else begin
                    rfc_cnt <= rfc_cnt - RFC_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dram_req_scheduler.sv
// Request queue between trace parser and DRAM command side: open-row-hit
// priority with age override. Latency: accepted at edge N, eligible from
// edge N+1, out_valid the cycle after the issuing edge. Backpressure: in_ready low when full or request is in the future.
//
// Ports: in_* parser request (valid/ready), queue_full/queue_count status,
//        curr_time scheduler time, refresh_active, out_* registered issue pulse.
module dram_req_scheduler
    import dram_req_scheduler_pkg::*;
#(
    parameter int QUEUE_SIZE = 16,
    parameter int ADDR_W     = 33,
    parameter int TIME_W     = 64,
    parameter int AGE_W      = 8,
    parameter int AGE_LIMIT  = 100,
    parameter int ISSUE_DIV  = 2,
    parameter int T_REFI     = 7800,
    parameter int T_RFC      = 350
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [1:0]                    in_opcode,
    input  logic [ADDR_W-1:0]             in_address,
    input  logic [TIME_W-1:0]             in_time,
    output logic                          in_ready,
    output logic                          queue_full,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] queue_count,
    output logic [TIME_W-1:0]             curr_time,
    output logic                          refresh_active,
    output logic                          out_valid,
    output logic [1:0]                    out_opcode,
    output logic [ADDR_W-1:0]             out_address,
    output logic [3:0]                    out_bank,
    output logic [ROW_W-1:0]              out_row,
    output logic [COL_W-1:0]              out_col,
    output logic                          out_row_hit
);

    localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
    localparam int IDX_W = $clog2(QUEUE_SIZE);
    localparam int DIV_W = (ISSUE_DIV > 1) ? $clog2(ISSUE_DIV) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);

    // Slot storage
    logic [QUEUE_SIZE-1:0] slot_vld;
    opcode_t               slot_op   [QUEUE_SIZE];
    logic [ADDR_W-1:0]     slot_addr [QUEUE_SIZE];
    logic [AGE_W-1:0]      slot_age  [QUEUE_SIZE];
    logic [BANK_ID_W-1:0]  slot_bank [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0] slot_hit;

    bank_status_t bank_status [NUM_BANKS];

    logic [CNT_W-1:0]  count_q;
    logic [TIME_W-1:0] time_q;
    logic [DIV_W-1:0]  div_cnt;
    logic              refresh_start;

    logic             any_found, hit_found;
    logic [IDX_W-1:0] any_idx, hit_idx, sel_idx, free_idx;
    logic [AGE_W-1:0] any_age, hit_age;

    logic [ADDR_W-1:0]    sel_addr;
    logic [BANK_ID_W-1:0] sel_bank;
    logic [ROW_W-1:0]     sel_row;
    logic [COL_W-1:0]     sel_col;

    logic tick, issue, accept;

    dram_req_scheduler_refresh_timer #(
        .T_REFI (T_REFI),
        .T_RFC  (T_RFC)
    ) u_refresh_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .refresh_active (refresh_active),
        .refresh_start  (refresh_start)
    );

    assign queue_full  = (count_q == CNT_W'(QUEUE_SIZE));
    assign queue_count = count_q;
    assign curr_time   = time_q;
    // Requests from the future wait unless the queue is empty, where time skips ahead.
    assign in_ready    = !queue_full && ((count_q == '0) || (time_q >= in_time));
    assign accept      = in_valid && in_ready;

    assign tick  = (div_cnt == '0);
    // refresh_start also blocks issue so no pulse lands in the first refresh cycle.
    assign issue = tick && !refresh_active && !refresh_start && any_found;

    // Per-slot bank decode and open-row hit against current bank state
    always_comb begin
        slot_hit = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            slot_bank[i] = {slot_addr[i][BG_OFFSET +: BG_W] & BG_MASK,
                            slot_addr[i][BANK_OFFSET +: BANK_W] & BANK_MASK};
            slot_hit[i]  = bank_status[slot_bank[i]].open &&
                           (bank_status[slot_bank[i]].row ==
                            (slot_addr[i][ROW_OFFSET +: ROW_W] & ROW_MASK));
        end
    end

    // Oldest overall and oldest row hit; strict '>' keeps the lowest slot on ties.
    always_comb begin
        any_found = 1'b0;
        any_idx   = '0;
        any_age   = '0;
        hit_found = 1'b0;
        hit_idx   = '0;
        hit_age   = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (slot_vld[i]) begin
                if (!any_found || (slot_age[i] > any_age)) begin
                    any_found = 1'b1;
                    any_idx   = IDX_W'(i);
                    any_age   = slot_age[i];
                end
                if (slot_hit[i] && (!hit_found || (slot_age[i] > hit_age))) begin
                    hit_found = 1'b1;
                    hit_idx   = IDX_W'(i);
                    hit_age   = slot_age[i];
                end
            end
        end
        // The oldest overall entry is also the oldest among any past the limit.
        if (any_age >= AGE_LIM) begin
            sel_idx = any_idx;
        end else if (hit_found) begin
            sel_idx = hit_idx;
        end else begin
            sel_idx = any_idx;
        end
    end

    // Lowest free slot; valid bits are registered, so a slot freed this
    // cycle only shows as free next cycle.
    always_comb begin
        free_idx = '0;
        for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
            if (!slot_vld[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_addr = slot_addr[sel_idx];
        sel_bank = slot_bank[sel_idx];
        sel_row  = sel_addr[ROW_OFFSET +: ROW_W] & ROW_MASK;
        sel_col  = sel_addr[COLUMN_OFFSET +: COL_W] & COL_MASK;
    end

    // Queue slots, occupancy and scheduler time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                slot_op[i]   <= OP_READ;
                slot_addr[i] <= '0;
                slot_age[i]  <= '0;
            end
            count_q <= '0;
            time_q  <= '0;
        end else begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                if (slot_vld[i] && (slot_age[i] != AGE_MAX)) begin
                    slot_age[i] <= slot_age[i] + AGE_W'(1);
                end
            end
            if (issue) begin
                slot_vld[sel_idx] <= 1'b0;
            end
            if (accept) begin
                slot_vld[free_idx]  <= 1'b1;
                slot_op[free_idx]   <= opcode_t'(in_opcode);
                slot_addr[free_idx] <= in_address;
                slot_age[free_idx]  <= '0;
            end

            if (accept && !issue) begin
                count_q <= count_q + CNT_W'(1);
            end else if (issue && !accept) begin
                count_q <= count_q - CNT_W'(1);
            end

            if ((count_q == '0) && in_valid && (in_time > time_q)) begin
                time_q <= in_time;
            end else begin
                time_q <= time_q + TIME_W'(1);
            end
        end
    end

    // Issue-rate divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_W'(ISSUE_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Per-bank open-row tracking; refresh precharges every bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_status[b] <= '0;
            end
        end else if (refresh_start) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_status[b] <= '0;
            end
        end else if (issue) begin
            bank_status[sel_bank] <= {1'b1, sel_row};
        end
    end

    // Registered issue outputs; data holds between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_address <= '0;
            out_bank    <= '0;
            out_row     <= '0;
            out_col     <= '0;
            out_row_hit <= 1'b0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_opcode  <= slot_op[sel_idx];
            out_address <= sel_addr;
            out_bank    <= sel_bank;
            out_row     <= sel_row;
            out_col     <= sel_col;
            out_row_hit <= slot_hit[sel_idx];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
